// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating multiplexer with a one-entry registered
// output stage and valid/ready handshakes on both sides. Arbitration is
// round-robin (MODE=0) or fixed priority with channel 0 highest (MODE=1).
// A saturating stall counter reports how long the consumer has held off.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel,
    output logic [7:0]           busy_cnt
);

    // Registered state and its next-state values
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic [7:0]       busy_q,      busy_d;

    // Arbitration results
    logic             load_en;
    logic             grant_any;
    logic [SELW-1:0]  grant_idx;
    logic [NCH-1:0]   grant_vec;
    int               cand;
    logic [SELW-1:0]  cand_sel;

    // Per-channel view of the flattened data bus
    logic [WIDTH-1:0] chan_data [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_unpack
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register can accept a new word when empty or being drained
    assign load_en = !out_valid_q || out_ready;

    // Grant search: round-robin starts one past the last winner, fixed
    // priority always starts at channel 0. Candidates are always < NCH,
    // so non-power-of-two channel counts never select a missing channel.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_sel  = '0;
        if (load_en) begin
            for (int k = 0; k < NCH; k++) begin
                if (MODE == 1) begin
                    cand = k;
                end else begin
                    cand = (int'(ptr_q) + 1 + k) % NCH;
                end
                cand_sel = SELW'(cand);
                if (!grant_any && in_valid[cand_sel]) begin
                    grant_any           = 1'b1;
                    grant_idx           = cand_sel;
                    grant_vec[cand_sel] = 1'b1;
                end
            end
        end
    end

    assign in_ready = grant_vec;

    // Next-state for the output register, pointer and stall counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;

        if (grant_any) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[grant_idx];
            out_sel_d   = grant_idx;
            if (MODE == 0) begin
                ptr_d = grant_idx;
            end
        end else if (load_en) begin
            // Drained (or still empty) with nothing to load: data/sel keep
            // their stale values, only the valid flag drops.
            out_valid_d = 1'b0;
        end

        if (out_valid_q && !out_ready) begin
            if (busy_q != 8'hFF) begin
                busy_d = busy_q + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            busy_d = 8'd0;
        end
    end

    // State registers; reset leaves the pointer on the last channel so the
    // first search begins at channel 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= SELW'(NCH - 1);
            busy_q      <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: three instances (4ch round-robin, 4ch fixed
// priority, 3ch round-robin) share one stimulus stream and are each checked
// against a transaction-level model of the arbitration rules.
module tb_rr_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  vld;
    logic        ordy;
    logic [7:0]  d [4];
    logic [31:0] in_flat;

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [7:0]  od0, od1, od2;
    logic        ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;
    logic [7:0]  bc0, bc1, bc2;

    // Observed outputs gathered per instance
    logic [3:0]  o_ir [3];
    logic [7:0]  o_d  [3];
    logic        o_v  [3];
    logic [1:0]  o_s  [3];
    logic [7:0]  o_b  [3];

    // Reference model state per instance
    int          nch_of  [3] = '{4, 4, 3};
    int          mode_of [3] = '{0, 1, 0};
    logic        m_valid [3];
    logic [7:0]  m_data  [3];
    int          m_sel   [3];
    int          m_ptr   [3];
    int          m_busy  [3];

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    assign in_flat = {d[3], d[2], d[1], d[0]};

    rr_arb_mux #(.WIDTH(8), .NCH(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat), .in_valid(vld),
        .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(ordy),
        .out_sel(os0), .busy_cnt(bc0));

    rr_arb_mux #(.WIDTH(8), .NCH(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat), .in_valid(vld),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(ordy),
        .out_sel(os1), .busy_cnt(bc1));

    rr_arb_mux #(.WIDTH(8), .NCH(3), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_flat[23:0]), .in_valid(vld[2:0]),
        .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(ordy),
        .out_sel(os2), .busy_cnt(bc2));

    assign o_ir[0] = ir0;
    assign o_ir[1] = ir1;
    assign o_ir[2] = {1'b0, ir2};
    assign o_d[0] = od0;  assign o_d[1] = od1;  assign o_d[2] = od2;
    assign o_v[0] = ov0;  assign o_v[1] = ov1;  assign o_v[2] = ov2;
    assign o_s[0] = os0;  assign o_s[1] = os1;  assign o_s[2] = os2;
    assign o_b[0] = bc0;  assign o_b[1] = bc1;  assign o_b[2] = bc2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
        end
    endtask

    // Winner by rule: round-robin walks the channels after the last winner,
    // fixed priority takes the lowest requesting channel; -1 if none request.
    function automatic int pick(input logic [3:0] v, input int nch, input int mode, input int ptr);
        for (int k = 1; k <= nch; k++) begin
            int c;
            c = (mode == 1) ? (k - 1) : ((ptr + k) % nch);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = 8'h00;
            m_sel[k]   = 0;
            m_ptr[k]   = nch_of[k] - 1;
            m_busy[k]  = 0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_valid%0d", pfx, k), 32'(o_v[k]), 32'(m_valid[k]));
            check($sformatf("%s_data%0d", pfx, k), 32'(o_d[k]), 32'(m_data[k]));
            check($sformatf("%s_sel%0d", pfx, k), 32'(o_s[k]), 32'(m_sel[k]));
            check($sformatf("%s_busy%0d", pfx, k), 32'(o_b[k]), 32'(m_busy[k]));
        end
    endtask

    // One clock of stimulus, called just after a falling edge
    task automatic step(input logic [3:0] v, input logic r);
        int g [3];
        logic [3:0] vm;
        vld  = v;
        ordy = r;
        step_no++;
        #1;
        for (int k = 0; k < 3; k++) begin
            vm = (nch_of[k] == 3) ? {1'b0, v[2:0]} : v;
            if (!m_valid[k] || r) g[k] = pick(vm, nch_of[k], mode_of[k], m_ptr[k]);
            else                  g[k] = -1;
            check($sformatf("in_ready%0d", k), 32'(o_ir[k]),
                  (g[k] >= 0) ? (32'd1 << g[k]) : 32'd0);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (m_valid[k] && !r)     m_busy[k] = (m_busy[k] < 255) ? m_busy[k] + 1 : 255;
            else if (m_valid[k] && r) m_busy[k] = 0;
            if (g[k] >= 0) begin
                m_valid[k] = 1'b1;
                m_data[k]  = d[g[k]];
                m_sel[k]   = g[k];
                if (mode_of[k] == 0) m_ptr[k] = g[k];
            end else if (!m_valid[k] || r) begin
                m_valid[k] = 1'b0;
            end
        end
        #1;
        check_outputs("out");
        $display("step %0d vld=%b ordy=%b | v/s/d0=%0d/%0d/%h v/s/d1=%0d/%0d/%h v/s/d2=%0d/%0d/%h",
                 step_no, v, r, ov0, os0, od0, ov1, os1, od1, ov2, os2, od2);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse, checked between clock edges
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_data_default();
        for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 4'b0000;
        ordy  = 1'b0;
        set_data_default();
        model_reset();
        @(negedge clk);
        do_reset();

        // Pass-through: only channel 2 requests
        d[2] = 8'hA5;
        step(4'b0100, 1'b1);
        check("pt_sel", 32'(os0), 32'd2);
        check("pt_data", 32'(od0), 32'hA5);
        check("pt_valid", 32'(ov0), 32'd1);

        // Round-robin fairness from a fresh pointer
        do_reset();
        set_data_default();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1);
            check("rr4_sel", 32'(os0), 32'(i % 4));
            check("rr4_data", 32'(od0), 32'(8'h10 + 8'(i % 4)));
            check("rr3_sel", 32'(os2), 32'(i % 3));
        end

        // Backpressure: register holds channel 3's word while stalled
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0);
        check("bp_busy", 32'(bc0), 32'd5);
        check("bp_sel", 32'(os0), 32'd3);
        check("bp_data", 32'(od0), 32'h13);
        step(4'b1111, 1'b1);
        check("bp_clear", 32'(bc0), 32'd0);
        check("bp_next", 32'(os0), 32'd0);

        // Fixed priority: channel 1 always beats channel 3
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 1'b1);
            check("fp_sel", 32'(os1), 32'd1);
        end

        // Bubble: one idle cycle drops out_valid for exactly one cycle
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        check("bubble_lo", 32'(ov2), 32'd0);
        step(4'b1111, 1'b1);
        check("bubble_hi", 32'(ov2), 32'd1);

        // Reset mid-stall, then first grant follows the reset pointer
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        do_reset();
        step(4'b0010, 1'b1);
        check("rst_first", 32'(os0), 32'd1);
        check("rst_first3", 32'(os2), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] rv;
            logic       rr;
            for (int c = 0; c < 4; c++) d[c] = 8'($urandom);
            rv = 4'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            step(rv, rr);
        end

        // Long stall to exercise saturation
        step(4'b1111, 1'b1);
        for (int i = 0; i < 260; i++) step(4'($urandom), 1'b0);
        check("busy_sat", 32'(bc0), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
